// File: rtl/mac_unit_vert_param.sv
// Bit-serial (vertical) signed MAC: one weight bit-column per cycle, grouped activation select/complement.
// Define MAC_VERT_POOLING_EN to compile in the max-pooling comparator on the result.
module mac_unit_vert_param #(
   parameter int DATA_WIDTH   = 8,
   parameter int VEC_LENGTH   = 16,
   parameter int GROUP_SIZE   = 8,
   parameter int NUM_COLS     = DATA_WIDTH,
   parameter int ACC_WIDTH    = DATA_WIDTH + 16,
   parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
   localparam int NUM_GROUPS    = VEC_LENGTH / GROUP_SIZE,
   localparam int SEL_PER_GROUP = GROUP_SIZE / 2,
   localparam int SEL_WIDTH     = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1,
   localparam int CNT_WIDTH     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            in_valid,
   output logic                                            in_ready,
   input  logic [VEC_LENGTH*DATA_WIDTH-1:0]                act_in,
   input  logic                                            load_prev,
   input  logic [RESULT_WIDTH-1:0]                         result_prev,
   input  logic                                            is_pooling,
   input  logic                                            col_valid,
   input  logic [NUM_GROUPS*SEL_PER_GROUP*SEL_WIDTH-1:0]   act_sel,
   input  logic [NUM_GROUPS-1:0]                           skip_zero,
   output logic                                            out_valid,
   input  logic                                            out_ready,
   output logic [RESULT_WIDTH-1:0]                         result,
   output logic                                            busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state, next_state;

   logic signed [DATA_WIDTH-1:0] act_reg [NUM_GROUPS][GROUP_SIZE];
   logic signed [ACC_WIDTH-1:0]  sum_reg [NUM_GROUPS];
   logic signed [ACC_WIDTH-1:0]  sum_in  [NUM_GROUPS];
   logic signed [ACC_WIDTH-1:0]  acc, stage1, psum, col_total, col_signed, col_shifted;
   logic signed [RESULT_WIDTH-1:0] acc_slice;
   logic                         stage1_valid;
   logic [CNT_WIDTH-1:0]         col_cnt;
   logic [SEL_WIDTH-1:0]         sel_idx;
   logic                         start, accept, last_col;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) next_state = RUN;
         end
         RUN:   if (col_valid && last_col) next_state = DRAIN;
         DRAIN: next_state = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign start    = (state == IDLE) && in_valid;
   assign accept   = (state == RUN) && col_valid;
   assign last_col = (col_cnt == CNT_WIDTH'(NUM_COLS - 1));

   // Whole-group sums are formed once per job so each column only needs the selected half.
   always_comb begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
         sum_in[g] = '0;
         for (int i = 0; i < GROUP_SIZE; i++)
            sum_in[g] = sum_in[g]
                      + ACC_WIDTH'($signed(act_in[(g*GROUP_SIZE+i)*DATA_WIDTH +: DATA_WIDTH]));
      end
   end

   // A cleared skip bit means the selection names the zero-weight half, so use the complement.
   always_comb begin
      col_total = '0;
      psum      = '0;
      sel_idx   = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         psum = '0;
         for (int k = 0; k < SEL_PER_GROUP; k++) begin
            sel_idx = act_sel[(g*SEL_PER_GROUP+k)*SEL_WIDTH +: SEL_WIDTH];
            psum    = psum + ACC_WIDTH'(act_reg[g][sel_idx]);
         end
         col_total = col_total + (skip_zero[g] ? psum : (sum_reg[g] - psum));
      end
      col_signed  = last_col ? -col_total : col_total;
      col_shifted = col_signed << col_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int g = 0; g < NUM_GROUPS; g++) begin
            sum_reg[g] <= '0;
            for (int i = 0; i < GROUP_SIZE; i++) act_reg[g][i] <= '0;
         end
         acc          <= '0;
         stage1       <= '0;
         stage1_valid <= 1'b0;
         col_cnt      <= '0;
      end else begin
         stage1_valid <= accept;
         if (accept) begin
            stage1  <= col_shifted;
            col_cnt <= col_cnt + CNT_WIDTH'(1);
         end
         if (start) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
               sum_reg[g] <= sum_in[g];
               for (int i = 0; i < GROUP_SIZE; i++)
                  act_reg[g][i] <= act_in[(g*GROUP_SIZE+i)*DATA_WIDTH +: DATA_WIDTH];
            end
            acc     <= load_prev ? (ACC_WIDTH'($signed(result_prev)) << (ACC_WIDTH - RESULT_WIDTH)) : '0;
            col_cnt <= '0;
         end else if (stage1_valid) begin
            acc <= acc + stage1;
         end
      end
   end

   assign acc_slice = acc[ACC_WIDTH-1 -: RESULT_WIDTH];

`ifdef MAC_VERT_POOLING_EN
   logic                           pool_reg;
   logic signed [RESULT_WIDTH-1:0] prev_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         pool_reg <= 1'b0;
         prev_reg <= '0;
      end else if (start) begin
         pool_reg <= is_pooling;
         prev_reg <= result_prev;
      end
   end

   assign result = (pool_reg && (prev_reg > acc_slice)) ? prev_reg : acc_slice;
`else
   logic unused_pooling;
   assign unused_pooling = is_pooling;
   assign result         = acc_slice;
`endif

endmodule

// File: doc/mac_unit_vert_param.md
MAC_UNIT_VERT_PARAM -- requirements
Module: mac_unit_vert_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed activation width.
REQ-002 SHALL have parameter VEC_LENGTH, default 16: activations per job.
REQ-003 SHALL have parameter GROUP_SIZE, default 8: activations per group; NUM_GROUPS=VEC_LENGTH/GROUP_SIZE, SEL_PER_GROUP=GROUP_SIZE/2.
REQ-004 SHALL have parameter NUM_COLS, default DATA_WIDTH: weight bit-columns per job.
REQ-005 SHALL have parameters ACC_WIDTH, default DATA_WIDTH+16, and RESULT_WIDTH, default 2*DATA_WIDTH.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 reset, synchronous, active-high.
REQ-007 SHALL have: in_valid in 1; in_ready out 1; act_in in VEC_LENGTH x DATA_WIDTH signed; load_prev in 1; result_prev in RESULT_WIDTH signed; is_pooling in 1.
REQ-008 SHALL have: col_valid in 1; act_sel in NUM_GROUPS*SEL_PER_GROUP x clog2(GROUP_SIZE), in-group index; skip_zero in NUM_GROUPS.
REQ-009 SHALL have: out_valid out 1; out_ready in 1; result out RESULT_WIDTH signed; busy out 1.

Function
REQ-010 SHALL implement FSM IDLE, RUN, DRAIN, DONE; in_ready=1 only in IDLE; busy=1 in RUN/DRAIN/DONE.
REQ-011 IDLE: on in_valid, SHALL register act_in, result_prev, is_pooling, per-group sums sum_g; accumulator := load_prev ? {result_prev, zeros} : 0; col_cnt := 0; go RUN.
REQ-012 RUN: each cycle with col_valid SHALL accept one column; col_valid low stalls, col_cnt holds.
REQ-013 Per column, group g: psum_g = sum of SEL_PER_GROUP registered acts chosen by act_sel; term_g = skip_zero[g] ? psum_g : sum_g - psum_g.
REQ-014 Column total = sum of term_g, negated when col_cnt==NUM_COLS-1, shifted left by col_cnt, sign-extended to ACC_WIDTH.
REQ-015 Pipeline: stage 1 registers shifted total; stage 2 adds it to accumulator; accumulation wraps modulo 2^ACC_WIDTH.
REQ-016 After accepting column NUM_COLS-1 at cycle T, SHALL enter DRAIN; out_valid SHALL rise at T+2 (DONE) with final accumulator.
REQ-017 result = accumulator[ACC_WIDTH-1 -: RESULT_WIDTH], or pooled value per REQ-022; held stable while out_valid=1.
REQ-018 DONE: out_valid=1 until out_ready; on out_ready go IDLE; in_valid ignored outside IDLE.
REQ-019 col_valid in IDLE/DRAIN/DONE SHALL be ignored.

Reset
REQ-020 reset SHALL force IDLE, accumulator/pipeline/col_cnt 0, in_ready=1, out_valid=0, busy=0, result=0, including mid-job; no partial result emitted.

Configuration
REQ-021 Macro MAC_VERT_POOLING_EN SHALL compile in max-pooling comparator.
REQ-022 With MAC_VERT_POOLING_EN: if latched is_pooling=1, result = signed max(accumulator slice, latched result_prev); without it, is_pooling ignored, result = slice.

Verification
REQ-023 Defaults, all act_in=1, load_prev=0, act_sel 0..3 every group, skip_zero=1, 8 columns back-to-back -> out_valid 2 cycles after last column, result 16'hFFFF.
REQ-024 All act_in=2, load_prev=1, result_prev=16'h0002, skip_zero=0, act_sel 0..3, 8 columns -> accumulator 496, result 16'h0001.
REQ-025 REQ-023 with col_valid low 3 cycles after column 4 -> identical result, out_valid delayed 3 cycles.
REQ-026 REQ-023 with MAC_VERT_POOLING_EN, is_pooling=1, result_prev=16'h0005 -> result 16'h0005; macro undefined -> 16'hFFFF.
REQ-027 reset asserted after column 5 -> in_ready=1, out_valid=0 next cycle; new job REQ-023 yields 16'hFFFF.
REQ-028 out_ready low 4 cycles in DONE -> out_valid and result held; in_valid pulses ignored; IDLE after out_ready.
